req_rsp_responder: RTL

- Responder end of the 32-bit req/rsp valid-ready interface; sits opposite a TLM-driven request initiator.
- Accepts requests into a FIFO and computes response = request + INCR.
- Returns each response after a programmable delay under valid/ready backpressure.
- Keeps wrapping request/response transaction counters for bench scoreboarding.

---
 rtl/req_rsp_responder.sv | 117 +++++++++++
 1 files changed

// File: rtl/req_rsp_responder.sv
// rtl/req_rsp_responder.sv - responder end of a req/rsp valid-ready link: request FIFO, +INCR, delayed response
module req_rsp_responder #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int LATENCY = 2,
    parameter int INCR    = 1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [DATA_W-1:0]        req_data,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_W-1:0]        rsp_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     busy,
    output logic [31:0]              req_count,
    output logic [31:0]              rsp_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               avail;
    logic [7:0]         lat_cnt;
    logic               push;
    logic               pop;
    logic               rsp_done;
    logic [LW-1:0]      level_next;

    // A freshly written entry becomes readable one cycle after the write,
    // so avail trails (level != 0) by one clock.
    always_comb begin
        push       = req_valid && req_ready;
        pop        = (state == IDLE) && (level != '0) && avail;
        rsp_done   = (state == RESP) && rsp_ready;
        level_next = level + LW'(push) - LW'(pop);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (pop) begin
                    state_next = (LATENCY == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (lat_cnt == 8'd1) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= req_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            avail     <= 1'b0;
            req_ready <= 1'b0;
            state     <= IDLE;
            lat_cnt   <= 8'd0;
            rsp_data  <= '0;
            req_count <= 32'd0;
            rsp_count <= 32'd0;
        end else begin
            state     <= state_next;
            level     <= level_next;
            avail     <= (level != '0);
            req_ready <= (level_next < LW'(DEPTH));
            if (push) begin
                wr_ptr    <= wr_ptr + 1'b1;
                req_count <= req_count + 32'd1;
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                rsp_data <= mem[rd_ptr] + DATA_W'(INCR);
                lat_cnt  <= 8'(LATENCY);
            end else if (state == WAIT) begin
                lat_cnt <= lat_cnt - 8'd1;
            end
            if (rsp_done) begin
                rsp_count <= rsp_count + 32'd1;
            end
        end
    end

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE) || (level != '0);

endmodule
